fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Control sequencer for a time-multiplexed symmetric FIR filter. It owns the circular sample history buffer pointer, zero-fills the history after reset, and accepts one input sample per handshake. For each sample it steps a single shared pre-add/multiply-accumulate unit through all coefficient taps, then presents the accumulated result with a valid/ready handshake. It sits between the sample source and the MAC datapath (history RAM, coefficient ROM, pre-adder, accumulator) and carries no sample data itself.

## Interface
- TAPS, 12, filter length; even, 4..16
- ADDR_W, 4, history address width; 2**ADDR_W >= TAPS
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  source has a sample on the data bus
- in_ready  out  1  sequencer can accept a sample
- buf_we  out  1  history write strobe
- buf_wzero  out  1  write zero instead of input data (init fill)
- buf_waddr  out  ADDR_W  history write address
- rd_addr_a  out  ADDR_W  history read address, newer operand
- rd_addr_b  out  ADDR_W  history read address, older operand (pre-add partner)
- pair_en  out  1  pre-adder uses operand b; when 0, b is treated as zero
- coef_sel  out  ADDR_W  coefficient ROM index
- acc_clr  out  1  accumulator loads the product instead of adding it
- acc_en  out  1  accumulator updates this cycle
- mac_last  out  1  final MAC cycle of the current sample
- out_valid  out  1  accumulator holds a finished output
- out_ready  in  1  sink accepts the output

## Operation
- States: INIT, IDLE, MAC, DONE. Reset enters INIT with wptr=0, k=0, init_cnt=0.
- INIT: buf_we=1, buf_wzero=1, buf_waddr=init_cnt for TAPS cycles (0..TAPS-1), then IDLE. in_ready=0.
- IDLE: in_ready=1. buf_we = in_valid (combinational), buf_waddr=wptr, buf_wzero=0. On handshake: cur<=wptr, wptr<=wptr+1 (wraps TAPS-1 -> 0), k<=0, go to MAC.
- MAC, with folding (K=TAPS/2 cycles): rd_addr_a=(cur-k) mod TAPS, rd_addr_b=(cur+k+1) mod TAPS, pair_en=1, coef_sel=k.
- acc_en=1 on every MAC cycle; acc_clr=1 only at k=0; mac_last=1 at k=K-1. After k=K-1, go to DONE.
- DONE: out_valid=1, held until out_ready=1. On that edge go to IDLE. Output values are stable while stalled.
- Modulo arithmetic on ADDR_W bits with explicit wrap at TAPS; no reliance on power-of-2 overflow.
- Outside their states, all strobes are 0 and addresses hold their last value.
- Reset asserted mid-MAC or mid-DONE aborts the sample with no output, and zero-fill restarts.

## Timing
- All outputs are 0 while rst is high, including the combinational buf_we.
- After rst falls: TAPS INIT cycles; in_ready rises in cycle TAPS+1.
- Handshake at edge E0 writes the sample at E0. MAC cycles occupy E0..E(K). out_valid is high in the cycle after E(K).
- Minimum sample period: K+2 cycles (8 at TAPS=12 folded). in_ready is low from E0 until DONE exits.
- in_valid during INIT, MAC or DONE is ignored; the source holds it.
- out_ready high before DONE: out_valid is high for exactly one cycle.

## Configuration
- FIR_SEQ_FOLD_EN defined: symmetric folding as above, K=TAPS/2, pair_en=1.
- Not defined: K=TAPS MAC cycles, pair_en=0, rd_addr_b=rd_addr_a=(cur-k) mod TAPS, coef_sel = k for k<TAPS/2 else TAPS-1-k. Minimum period is TAPS+2 (14).

## Test plan
- Reset release, TAPS=12: buf_we/buf_wzero high 12 cycles with buf_waddr 0..11, then in_ready=1; no strobe while rst is high.
- Folded, first sample (wptr=0): rd_addr_a = 0,11,10,9,8,7 and rd_addr_b = 1,2,3,4,5,6, coef_sel 0..5, acc_clr only on the first cycle, mac_last on the sixth, out_valid 7 cycles after the handshake edge.
- 13 back-to-back samples with out_ready=1: buf_waddr wraps 11 -> 0, the period is exactly 8 cycles, and sample 13 has cur=0.
- out_ready low for 5 cycles in DONE: out_valid stays high, in_ready stays 0, and rd_addr/coef_sel are unchanged.
- rst pulse at the third MAC cycle: outputs go to 0 at once, no out_valid, and a full 12-cycle zero-fill runs after release.
- FIR_SEQ_FOLD_EN undefined: 12 MAC cycles, coef_sel 0,1,2,3,4,5,5,4,3,2,1,0, pair_en=0, period 14.

Source files
------------

// File: rtl/fir_seq_if.sv
// Handshake and MAC-control bundle between the FIR sequencer and its
// sample source, sink and datapath.
interface fir_seq_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              buf_we;
  logic              buf_wzero;
  logic [ADDR_W-1:0] buf_waddr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              pair_en;
  logic [ADDR_W-1:0] coef_sel;
  logic              acc_clr;
  logic              acc_en;
  logic              mac_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  in_valid, out_ready,
    output in_ready, buf_we, buf_wzero, buf_waddr, rd_addr_a, rd_addr_b,
           pair_en, coef_sel, acc_clr, acc_en, mac_last, out_valid
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, buf_we, buf_wzero, buf_waddr, rd_addr_a, rd_addr_b,
           pair_en, coef_sel, acc_clr, acc_en, mac_last, out_valid
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a time-multiplexed symmetric FIR: history pointer,
// zero-fill, per-sample tap stepping. Define FIR_SEQ_FOLD_EN for symmetric folding.
//
//   state | meaning
//   INIT  | zero-fill history, one address per cycle
//   IDLE  | ready for a sample; write it on handshake
//   MAC   | step shared MAC through taps
//   DONE  | hold finished output until sink takes it
module fir_mac_sequencer #(
  parameter int TAPS   = 12,
  parameter int ADDR_W = 4
) (
  input  logic      clk,
  input  logic      rst,
  fir_seq_if.master seq
);

`ifdef FIR_SEQ_FOLD_EN
  localparam int   K        = TAPS / 2;
  localparam logic PAIR_USE = 1'b1;
`else
  localparam int   K        = TAPS;
  localparam logic PAIR_USE = 1'b0;
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(TAPS / 2);
`endif

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(K - 1);
  localparam logic [ADDR_W:0]   TAPS_X   = (ADDR_W+1)'(TAPS);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_MAC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] addr_new;
  logic [ADDR_W-1:0] addr_old;
  logic [ADDR_W-1:0] coef_k;

  // (a - b) mod TAPS for a, b < TAPS; wraps explicitly rather than on 2**ADDR_W
  function automatic logic [ADDR_W-1:0] mod_sub(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + TAPS_X - {1'b0, b};
    return t[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_TAP) ? '0 : a + 1'b1;
  endfunction

`ifdef FIR_SEQ_FOLD_EN
  // (a + b + 1) mod TAPS; the sum never reaches 2*TAPS
  function automatic logic [ADDR_W-1:0] mod_add1(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b} + 1'b1;
    if (s >= TAPS_X) s = s - TAPS_X;
    return s[ADDR_W-1:0];
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:  if (init_cnt == LAST_TAP) state_nxt = S_IDLE;
      S_IDLE:  if (seq.in_valid) state_nxt = S_MAC;
      S_MAC:   if (k == LAST_K) state_nxt = S_DONE;
      S_DONE:  if (seq.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= '0;
      wptr     <= '0;
      cur      <= '0;
      k        <= '0;
    end else begin
      unique case (state)
        S_INIT: init_cnt <= wrap_inc(init_cnt);
        S_IDLE: begin
          if (seq.in_valid) begin
            cur  <= wptr;
            wptr <= wrap_inc(wptr);
            k    <= '0;
          end
        end
        // k parks on its last value so DONE/IDLE keep presenting the last tap
        S_MAC:  if (k != LAST_K) k <= k + 1'b1;
        default: ;
      endcase
    end
  end

  assign addr_new = mod_sub(cur, k);
`ifdef FIR_SEQ_FOLD_EN
  assign addr_old = mod_add1(cur, k);
  assign coef_k   = k;
`else
  assign addr_old = addr_new;
  assign coef_k   = (k < HALF) ? k : LAST_TAP - k;
`endif

  // rst gates every output, since INIT itself would otherwise drive buf_we
  always_comb begin
    seq.in_ready  = 1'b0;
    seq.buf_we    = 1'b0;
    seq.buf_wzero = 1'b0;
    seq.buf_waddr = '0;
    seq.rd_addr_a = '0;
    seq.rd_addr_b = '0;
    seq.pair_en   = 1'b0;
    seq.coef_sel  = '0;
    seq.acc_clr   = 1'b0;
    seq.acc_en    = 1'b0;
    seq.mac_last  = 1'b0;
    seq.out_valid = 1'b0;
    if (!rst) begin
      seq.buf_waddr = cur;
      seq.rd_addr_a = addr_new;
      seq.rd_addr_b = addr_old;
      seq.coef_sel  = coef_k;
      unique case (state)
        S_INIT: begin
          seq.buf_we    = 1'b1;
          seq.buf_wzero = 1'b1;
          seq.buf_waddr = init_cnt;
        end
        S_IDLE: begin
          seq.in_ready  = 1'b1;
          seq.buf_we    = seq.in_valid;
          seq.buf_waddr = wptr;
        end
        S_MAC: begin
          seq.pair_en  = PAIR_USE;
          seq.acc_en   = 1'b1;
          seq.acc_clr  = (k == '0);
          seq.mac_last = (k == LAST_K);
        end
        S_DONE:  seq.out_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: handshakes push expected MAC beats
// and outputs; a negedge monitor pops and compares.
module tb_fir_mac_sequencer;
  localparam int TAPS   = 12;
  localparam int ADDR_W = 4;
`ifdef FIR_SEQ_FOLD_EN
  localparam int KB = TAPS / 2;
`else
  localparam int KB = TAPS;
`endif

  typedef struct {
    int cyc;
    int a;
    int b;
    int pair;
    int coef;
    int clr;
    int last;
  } beat_t;

  typedef struct {
    int cur;
    int hs_cyc;
    bit seen;
  } out_t;

  logic clk;
  logic rst;
  fir_seq_if #(.ADDR_W(ADDR_W)) bus ();

  fir_mac_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .seq(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int exp_wptr = 0;
  int init_idx = 0;
  int prev_hs = 0;
  bit prev_valid = 0;
  bit b2b = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  beat_t beat_q[$];
  out_t  out_q[$];
  beat_t last_b = '{0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    beat_t bt;
    out_t  ot;
    if (tmo_cnt != tmo_seen) begin
      chk("wait_timeout", tmo_cnt, tmo_seen);
      tmo_seen = tmo_cnt;
    end
    if (rst) begin
      chk("reset_outputs", int'({bus.in_ready, bus.buf_we, bus.buf_wzero, bus.buf_waddr,
                                 bus.rd_addr_a, bus.rd_addr_b, bus.pair_en, bus.coef_sel,
                                 bus.acc_clr, bus.acc_en, bus.mac_last, bus.out_valid}), 0);
      beat_q.delete();
      out_q.delete();
      exp_wptr   = 0;
      init_idx   = 0;
      prev_valid = 0;
    end else begin
      cyc++;
      if (init_idx < TAPS) begin
        chk("init_we_wzero", int'({bus.buf_we, bus.buf_wzero}), 3);
        chk("init_waddr", int'(bus.buf_waddr), init_idx);
        chk("init_in_ready", int'(bus.in_ready), 0);
        chk("init_acc_out", int'({bus.acc_en, bus.out_valid}), 0);
        init_idx++;
      end else begin
        chk("in_ready", int'(bus.in_ready), (out_q.size() != 0) ? 0 : 1);
        chk("buf_we", int'(bus.buf_we), int'(bus.in_valid && bus.in_ready));
        if (bus.in_valid && bus.in_ready) begin
          chk("hs_waddr", int'(bus.buf_waddr), exp_wptr);
          chk("hs_wzero", int'(bus.buf_wzero), 0);
          if (!b2b) prev_valid = 0;
          if (prev_valid) chk("period", cyc - prev_hs, KB + 2);
          prev_hs    = cyc;
          prev_valid = b2b;
          for (int j = 0; j < KB; j++) begin
            bt.cyc = cyc + 1 + j;
            bt.a   = (exp_wptr - j + TAPS) % TAPS;
`ifdef FIR_SEQ_FOLD_EN
            bt.b    = (exp_wptr + j + 1) % TAPS;
            bt.pair = 1;
            bt.coef = j;
`else
            bt.b    = bt.a;
            bt.pair = 0;
            bt.coef = (j < TAPS / 2) ? j : TAPS - 1 - j;
`endif
            bt.clr  = (j == 0) ? 1 : 0;
            bt.last = (j == KB - 1) ? 1 : 0;
            beat_q.push_back(bt);
          end
          ot.cur    = exp_wptr;
          ot.hs_cyc = cyc;
          ot.seen   = 0;
          out_q.push_back(ot);
          exp_wptr = (exp_wptr + 1) % TAPS;
          hs_count++;
        end
        if (bus.acc_en) begin
          if (beat_q.size() == 0) chk("spurious_acc_en", 1, 0);
          else begin
            bt = beat_q.pop_front();
            chk("beat_cycle", cyc, bt.cyc);
            chk("rd_addr_a", int'(bus.rd_addr_a), bt.a);
            chk("rd_addr_b", int'(bus.rd_addr_b), bt.b);
            chk("pair_en", int'(bus.pair_en), bt.pair);
            chk("coef_sel", int'(bus.coef_sel), bt.coef);
            chk("acc_clr", int'(bus.acc_clr), bt.clr);
            chk("mac_last", int'(bus.mac_last), bt.last);
            last_b = bt;
          end
        end else if (beat_q.size() != 0 && beat_q[0].cyc <= cyc) begin
          chk("acc_en_missing", 0, 1);
          void'(beat_q.pop_front());
        end
        if (bus.out_valid) begin
          if (out_q.size() == 0) chk("spurious_out_valid", 1, 0);
          else begin
            chk("out_before_mac_end", beat_q.size(), 0);
            if (!out_q[0].seen) begin
              chk("out_latency", cyc - out_q[0].hs_cyc, KB + 1);
              out_q[0].seen = 1;
            end
            chk("hold_rd_addr_a", int'(bus.rd_addr_a), last_b.a);
            chk("hold_rd_addr_b", int'(bus.rd_addr_b), last_b.b);
            chk("hold_coef_sel", int'(bus.coef_sel), last_b.coef);
            chk("done_strobes", int'({bus.acc_en, bus.acc_clr, bus.mac_last, bus.pair_en}), 0);
            if (bus.out_ready) void'(out_q.pop_front());
          end
        end else if (out_q.size() != 0 &&
                     (out_q[0].seen || cyc > out_q[0].hs_cyc + KB + 1)) begin
          chk("out_valid_missing", 0, 1);
          void'(out_q.pop_front());
        end
      end
    end
  end

  task automatic wait_ready(input int lim);
    bit got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
    end
    if (!got) tmo_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_phase(input int n);
    int last_hs = hs_count;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (!bus.in_valid || hs_count != last_hs) bus.in_valid = ($urandom_range(0, 2) == 0);
      last_hs = hs_count;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    int n0;
    bit got;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    bus.in_valid = 1'b0;
    wait_ready(TAPS + 10);

    // back-to-back samples, wrap of the history pointer
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    b2b           = 1'b1;
    n0 = hs_count;
    for (int i = 0; i < 13 * (KB + 2) + 40 && hs_count < n0 + 13; i++) @(posedge clk);
    if (hs_count < n0 + 13) tmo_cnt++;
    #1;
    bus.in_valid = 1'b0;
    b2b          = 1'b0;
    wait_ready(KB + 10);

    // sink stall in DONE
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    n0 = hs_count;
    for (int i = 0; i < 20 && hs_count == n0; i++) @(posedge clk);
    if (hs_count == n0) tmo_cnt++;
    #1;
    bus.in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < KB + 10 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1;
    end
    if (!got) tmo_cnt++;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_ready(10);

    rand_phase(600);

    // reset during the third MAC cycle
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_ready(KB + 20);
    bus.in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.acc_clr) got = 1;
    end
    if (!got) tmo_cnt++;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_ready(TAPS + 10);

    rand_phase(400);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_ready(KB + 20);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual %0d required 0", 1);
    $fatal(1, "simulation time limit");
  end
endmodule
